// File: rtl/free_list_ctrl.sv
// Physical-register free list for a 2-wide rename stage, with a speculative head, a commit head and a release tail.
// Optional FREELIST_BYPASS_EN: same-cycle releases may satisfy allocations beyond the stored entries.
module free_list_ctrl #(
    parameter int NPREG = 64,
    parameter int NAREG = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    input  logic       recover,
    input  logic       alloc1_req,
    input  logic       alloc2_req,
    output logic [5:0] rd1prn,
    output logic [5:0] rd2prn,
    output logic       alloc_ok,
    output logic       fl_stall,
    input  logic       rel1_en,
    input  logic       rel2_en,
    input  logic [5:0] rel1_prn,
    input  logic [5:0] rel2_prn,
    input  logic       cmt1_en,
    input  logic       cmt2_en,
    output logic [5:0] fl_count,
    output logic       fl_err
);

    localparam int         FLD   = NPREG - NAREG;
    localparam int         PW    = $clog2(FLD);
    localparam logic [5:0] FLD_C = 6'(FLD);

    logic [5:0]    entry [FLD];
    logic [PW-1:0] sh, ch, tl;
    logic [5:0]    count;
    // Allocated-but-uncommitted entries; disambiguates ch==sh and restores count on recover.
    logic [5:0]    spec_cnt;

    logic [1:0]    need, alloc_n, relsum, cmsum;
    logic          rel1_ok, rel2_ok, cm1_ok, cm2_ok, grant;
    logic [6:0]    avail;
    logic [5:0]    p0, p1;
    logic [PW-1:0] ch_next;

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input logic [1:0] inc);
        int s;
        s = int'(p) + int'(inc);
        if (s >= FLD) s -= FLD;
        return PW'(s);
    endfunction

    // A release into a full list or a commit past the speculative head is dropped.
    assign rel1_ok = rel1_en & (count < FLD_C);
    assign rel2_ok = rel2_en & ((count + {5'b0, rel1_ok}) < FLD_C);
    assign cm1_ok  = cmt1_en & (spec_cnt != 6'd0);
    assign cm2_ok  = cmt2_en & (spec_cnt > {5'b0, cm1_ok});

    assign need    = {1'b0, alloc1_req} + {1'b0, alloc2_req};
    assign relsum  = {1'b0, rel1_ok} + {1'b0, rel2_ok};
    assign cmsum   = {1'b0, cm1_ok} + {1'b0, cm2_ok};
`ifdef FREELIST_BYPASS_EN
    assign avail   = {1'b0, count} + {6'b0, rel1_ok} + {6'b0, rel2_ok};
`else
    assign avail   = {1'b0, count};
`endif
    assign alloc_ok = {5'b0, need} <= avail;
    assign fl_stall = (need != 2'd0) & ~alloc_ok;
    assign grant    = alloc_ok & ~stall & ~recover;
    assign alloc_n  = grant ? need : 2'd0;
    assign ch_next  = wrap_add(ch, cmsum);
    assign fl_count = count;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        rd1prn = 6'd0;
        rd2prn = 6'd0;
`ifdef FREELIST_BYPASS_EN
        p0 = (count != 6'd0) ? entry[sh] : (rel1_ok ? rel1_prn : rel2_prn);
        if (count > 6'd1)
            p1 = entry[wrap_add(sh, 2'd1)];
        else if (count == 6'd1)
            p1 = rel1_ok ? rel1_prn : rel2_prn;
        else
            p1 = rel2_prn;
`else
        p0 = entry[sh];
        p1 = entry[wrap_add(sh, 2'd1)];
`endif
        if (alloc_ok) begin
            if (alloc1_req) rd1prn = p0;
            if (alloc2_req) rd2prn = alloc1_req ? p1 : p0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the storage array is reset because it must hold the initial free prns NAREG..NPREG-1.
            for (int i = 0; i < FLD; i++) entry[i] <= 6'(NAREG + i);
            sh       <= '0;
            ch       <= '0;
            tl       <= '0;
            count    <= FLD_C;
            spec_cnt <= 6'd0;
            fl_err   <= 1'b0;
        end else begin
            if (rel1_ok) entry[tl] <= rel1_prn;
            if (rel2_ok) entry[wrap_add(tl, {1'b0, rel1_ok})] <= rel2_prn;
            tl <= wrap_add(tl, relsum);
            ch <= ch_next;
            if (recover) begin
                sh       <= ch_next;
                count    <= count + {4'b0, relsum} + spec_cnt - {4'b0, cmsum};
                spec_cnt <= 6'd0;
            end else begin
                sh       <= wrap_add(sh, alloc_n);
                count    <= count - {4'b0, alloc_n} + {4'b0, relsum};
                spec_cnt <= spec_cnt + {4'b0, alloc_n} - {4'b0, cmsum};
            end
            if ((rel1_en & ~rel1_ok) | (rel2_en & ~rel2_ok) | (cmt1_en & ~cm1_ok) | (cmt2_en & ~cm2_ok))
                fl_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_free_list_ctrl.sv
// Scoreboard bench for free_list_ctrl: directed vectors push expected outputs, a monitor compares them.
module tb_free_list_ctrl;

    logic       clk = 1'b0;
    logic       rst, stall, recover, alloc1_req, alloc2_req;
    logic       rel1_en, rel2_en, cmt1_en, cmt2_en;
    logic [5:0] rel1_prn, rel2_prn;
    logic [5:0] rd1prn, rd2prn, fl_count;
    logic       alloc_ok, fl_stall, fl_err;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [5:0] rd1, rd2;
        logic       ok, fst;
        logic [5:0] cnt;
        logic       err;
        string      name;
    } exp_t;

    exp_t q[$];

    free_list_ctrl dut (
        .clk(clk), .rst(rst), .stall(stall), .recover(recover),
        .alloc1_req(alloc1_req), .alloc2_req(alloc2_req),
        .rd1prn(rd1prn), .rd2prn(rd2prn), .alloc_ok(alloc_ok), .fl_stall(fl_stall),
        .rel1_en(rel1_en), .rel2_en(rel2_en), .rel1_prn(rel1_prn), .rel2_prn(rel2_prn),
        .cmt1_en(cmt1_en), .cmt2_en(cmt2_en), .fl_count(fl_count), .fl_err(fl_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: outputs are stable by the falling edge, half a cycle after inputs change.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check({e.name, ".rd1prn"},   int'(rd1prn),   int'(e.rd1));
                check({e.name, ".rd2prn"},   int'(rd2prn),   int'(e.rd2));
                check({e.name, ".alloc_ok"}, int'(alloc_ok), int'(e.ok));
                check({e.name, ".fl_stall"}, int'(fl_stall), int'(e.fst));
                check({e.name, ".fl_count"}, int'(fl_count), int'(e.cnt));
                check({e.name, ".fl_err"},   int'(fl_err),   int'(e.err));
            end
        end
    end

    task automatic idle_inputs();
        stall = 0; recover = 0; alloc1_req = 0; alloc2_req = 0;
        rel1_en = 0; rel2_en = 0; rel1_prn = 0; rel2_prn = 0;
        cmt1_en = 0; cmt2_en = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    // One cycle of stimulus; expected outputs refer to this same cycle (fl_count/fl_err are pre-edge state).
    task automatic step(input logic a1, a2, st, rc,
                        input logic r1e, input logic [5:0] r1p,
                        input logic r2e, input logic [5:0] r2p,
                        input logic c1, c2,
                        input logic [5:0] e1, e2, input logic eok, efs,
                        input logic [5:0] ecnt, input logic eerr, input string nm);
        exp_t e;
        @(posedge clk); #1;
        alloc1_req = a1; alloc2_req = a2; stall = st; recover = rc;
        rel1_en = r1e; rel1_prn = r1p; rel2_en = r2e; rel2_prn = r2p;
        cmt1_en = c1; cmt2_en = c2;
        e.rd1 = e1; e.rd2 = e2; e.ok = eok; e.fst = efs; e.cnt = ecnt; e.err = eerr; e.name = nm;
        q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        rst = 1;
        do_reset();

        // Reset state, first pair allocation, then 15 more pairs until empty.
        step(0,0,0,0, 0,0, 0,0, 0,0,  0,  0, 1,0, 32, 0, "reset_idle");
        step(1,1,0,0, 0,0, 0,0, 0,0, 32, 33, 1,0, 32, 0, "first_pair");
        step(0,0,0,0, 0,0, 0,0, 0,0,  0,  0, 1,0, 30, 0, "count_after_pair");
        for (int i = 1; i < 16; i++)
            step(1,1,0,0, 0,0, 0,0, 0,0, 6'(32+2*i), 6'(33+2*i), 1,0, 6'(32-2*i), 0, "drain_pair");
        step(1,0,0,0, 0,0, 0,0, 0,0,  0,  0, 0,1,  0, 0, "empty_alloc1");
        step(1,1,0,0, 0,0, 0,0, 0,0,  0,  0, 0,1,  0, 0, "empty_alloc2");
`ifdef FREELIST_BYPASS_EN
        step(1,0,0,0, 1,5, 0,0, 0,0,  5,  0, 1,0,  0, 0, "bypass_grant");
        step(1,0,0,0, 0,0, 0,0, 0,0,  0,  0, 0,1,  0, 0, "bypass_after");
`else
        step(1,0,0,0, 1,5, 0,0, 0,0,  0,  0, 0,1,  0, 0, "rel_no_bypass");
        step(1,0,0,0, 0,0, 0,0, 0,0,  5,  0, 1,0,  1, 0, "rel_next_cycle");
`endif

        // Count=1: both requests refused, then slot 2 alone gets entry[sh]=63.
        do_reset();
        for (int i = 0; i < 15; i++)
            step(1,1,0,0, 0,0, 0,0, 0,0, 6'(32+2*i), 6'(33+2*i), 1,0, 6'(32-2*i), 0, "fill_pair");
        step(1,0,0,0, 0,0, 0,0, 0,0, 62,  0, 1,0,  2, 0, "alloc_to_one");
        step(1,1,0,0, 0,0, 0,0, 0,0,  0,  0, 0,1,  1, 0, "one_left_both");
        step(0,1,0,0, 0,0, 0,0, 0,0,  0, 63, 1,0,  1, 0, "one_left_slot2");
        step(0,0,0,0, 0,0, 0,0, 0,0,  0,  0, 1,0,  0, 0, "now_empty");

        // Allocate 6, commit 2, recover; stall holds the grant, then prn 34 is reissued.
        do_reset();
        step(1,1,0,0, 0,0, 0,0, 0,0, 32, 33, 1,0, 32, 0, "rec_a0");
        step(1,1,0,0, 0,0, 0,0, 0,0, 34, 35, 1,0, 30, 0, "rec_a1");
        step(1,1,0,0, 0,0, 0,0, 0,0, 36, 37, 1,0, 28, 0, "rec_a2");
        step(0,0,0,0, 0,0, 0,0, 1,1,  0,  0, 1,0, 26, 0, "rec_commit2");
        step(0,0,0,1, 0,0, 0,0, 0,0,  0,  0, 1,0, 26, 0, "rec_flush");
        step(1,1,1,0, 0,0, 0,0, 0,0, 34, 35, 1,0, 30, 0, "rec_stalled");
        step(1,0,0,0, 0,0, 0,0, 0,0, 34,  0, 1,0, 30, 0, "rec_realloc");
        step(0,0,0,0, 1,50, 1,51, 0,0, 0,  0, 1,0, 29, 0, "rel_pair");
        step(0,0,0,0, 0,0, 0,0, 0,0,  0,  0, 1,0, 31, 0, "rel_pair_count");

        // Release into a full list: sticky error, count unchanged.
        do_reset();
        step(0,0,0,0, 1,7, 0,0, 0,0,  0,  0, 1,0, 32, 0, "ovf_release");
        step(0,0,0,0, 0,0, 0,0, 0,0,  0,  0, 1,0, 32, 1, "ovf_flag");
        step(0,0,0,0, 0,0, 0,0, 0,0,  0,  0, 1,0, 32, 1, "ovf_sticky");
        do_reset();
        step(0,0,0,0, 0,0, 0,0, 0,0,  0,  0, 1,0, 32, 0, "err_cleared");
        step(0,0,0,0, 0,0, 0,0, 1,0,  0,  0, 1,0, 32, 0, "cmt_underflow");
        step(0,0,0,0, 0,0, 0,0, 0,0,  0,  0, 1,0, 32, 1, "cmt_err_flag");

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        check("scoreboard_drain", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
